// File: rtl/xadc_multi_monitor.sv
// xadc_multi_monitor
//   DRP read sequencer for the XADC wizard. On every XADC end-of-conversion it
//   reads NUM_CH status registers over DRP, optionally smooths each channel with
//   a first-order IIR filter, and publishes the results as a packed bank.
//
// Ports
//   clk, rst          system/DRP clock, synchronous active-high reset
//   eoc_in            XADC end-of-conversion pulse
//   drp_*             DRP master (read-only: dwe and di tied low)
//   ch_data           per-channel 12-bit results, ch k at [12k+:12]
//   ch_update         one-cycle pulse once a full sweep is in ch_data
//   drp_timeout_err   sticky, any DRP read abandoned for lack of drdy
//   eoc_overrun       sticky, eoc_in seen while a sweep was busy
//   temp_hi_thresh,
//   temp_alarm        ch 0 over-threshold alarm with 16-LSB hysteresis;
//                     present only when XADC_MON_ALARM_EN is defined
//
// State | meaning
//   IDLE  | waiting for eoc_in
//   REQ   | one-cycle DRP read request for channel idx
//   WAIT  | waiting for drdy, bounded by DRP_TIMEOUT
//   STORE | filter update of channel idx
//   NEXT  | advance to next channel or finish the sweep
module xadc_multi_monitor #(
  parameter int unsigned         NUM_CH      = 3,
  parameter logic [NUM_CH*7-1:0] CH_ADDR     = {7'h02, 7'h01, 7'h00},
  parameter int unsigned         AVG_SHIFT   = 0,
  parameter int unsigned         DRP_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   eoc_in,
  output logic [6:0]             drp_daddr,
  output logic                   drp_den,
  output logic                   drp_dwe,
  output logic [15:0]            drp_di,
  input  logic                   drp_drdy,
  input  logic [15:0]            drp_do,
`ifdef XADC_MON_ALARM_EN
  input  logic [11:0]            temp_hi_thresh,
  output logic                   temp_alarm,
`endif
  output logic [NUM_CH*12-1:0]   ch_data,
  output logic                   ch_update,
  output logic                   drp_timeout_err,
  output logic                   eoc_overrun
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TMO_W = $clog2(DRP_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRP_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STORE, S_NEXT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [11:0]        sample_q, sample_d;
  logic [6:0]         daddr_q, daddr_d;
  logic               den_q, den_d;
  logic               upd_q, upd_d;
  logic               err_q, err_d;
  logic               ovr_q, ovr_d;
  logic [NUM_CH-1:0]  first_q, first_d;
  logic [11:0]        ch_q [NUM_CH];
  logic [11:0]        ch_d [NUM_CH];

  logic [11:0]        cur_avg;
  logic signed [12:0] diff;
  logic signed [12:0] step;
  logic [11:0]        filt;

  // |diff >>> n| <= |diff|, so the 12-bit truncated sum never wraps.
  always_comb begin
    cur_avg = ch_q[idx_q];
    diff    = $signed({1'b0, sample_q}) - $signed({1'b0, cur_avg});
    step    = diff >>> AVG_SHIFT;
    filt    = cur_avg + step[11:0];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    sample_d = sample_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    first_d  = first_q;
    ch_d     = ch_q;
    unique case (state_q)
      S_IDLE: begin
        if (eoc_in) begin
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (drp_drdy) begin
          sample_d = drp_do[15:4];
          state_d  = S_STORE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_STORE: begin
        ch_d[idx_q]    = first_q[idx_q] ? filt : sample_q;
        first_d[idx_q] = 1'b1;
        state_d        = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Includes the cycle NEXT returns to IDLE: the sweep is still busy then.
    if (eoc_in && (state_q != S_IDLE)) ovr_d = 1'b1;
    // Registered outputs: den/daddr/ch_update are valid during REQ/NEXT.
    den_d   = (state_d == S_REQ);
    daddr_d = (state_d == S_REQ) ? CH_ADDR[32'(idx_d) * 7 +: 7] : daddr_q;
    upd_d   = (state_d == S_NEXT) && (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      tmo_q    <= '0;
      sample_q <= '0;
      daddr_q  <= '0;
      den_q    <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      first_q  <= '0;
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      sample_q <= sample_d;
      daddr_q  <= daddr_d;
      den_q    <= den_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      first_q  <= first_d;
      ch_q     <= ch_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_data[12*g +: 12] = ch_q[g];
  end

  assign drp_daddr       = daddr_q;
  assign drp_den         = den_q;
  assign drp_dwe         = 1'b0;
  assign drp_di          = '0;
  assign ch_update       = upd_q;
  assign drp_timeout_err = err_q;
  assign eoc_overrun     = ovr_q;

`ifdef XADC_MON_ALARM_EN
  logic alarm_q, alarm_d;
  logic store0_q, store0_d;

  // Compare one cycle after ch 0 is written, against the registered value.
  always_comb begin
    store0_d = (state_q == S_STORE) && (idx_q == '0);
    alarm_d  = alarm_q;
    if (store0_q) begin
      if (ch_q[0] >= temp_hi_thresh)
        alarm_d = 1'b1;
      else if (({1'b0, ch_q[0]} + 13'd16) <= {1'b0, temp_hi_thresh})
        alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q  <= 1'b0;
      store0_q <= 1'b0;
    end else begin
      alarm_q  <= alarm_d;
      store0_q <= store0_d;
    end
  end

  assign temp_alarm = alarm_q;
`endif

endmodule
